// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - host command parser bridging UART bytes to memA/memB/memC ports
// Frames: 'W' SEL AH AL D3 D2 D1 D0 -> ACK; 'R' SEL AH AL -> four data bytes, MSB first.
module uart_mem_bridge #(
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata_a,
  input  logic [31:0]       mem_rdata_b,
  input  logic [7:0]        mem_rdata_c,
  output logic              busy,
  output logic              cmd_err
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        CMD_W    = 8'h57;
  localparam logic [7:0]        CMD_R    = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_SEL, S_GET_AH, S_GET_AL, S_GET_DATA,
    S_MEM_WR, S_MEM_RD, S_RD_WAIT, S_TX_LOAD, S_TX_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        addr_h_q, addr_h_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       txbuf_q, txbuf_d;
  logic [1:0]        txidx_q, txidx_d;
  logic              txhold_q, txhold_d;
  logic [1:0]        mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              nak;
  logic [7:0]        tx_byte;
  logic [31:0]       rdata_sel;

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      sel_q      <= 2'd0;
      addr_h_q   <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      cnt_q      <= 2'd0;
      tmo_q      <= '0;
      txbuf_q    <= 32'd0;
      txidx_q    <= 2'd0;
      txhold_q   <= 1'b0;
      mem_sel_q  <= 2'd0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      sel_q      <= sel_d;
      addr_h_q   <= addr_h_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      txbuf_q    <= txbuf_d;
      txidx_q    <= txidx_d;
      txhold_q   <= txhold_d;
      mem_sel_q  <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Response bytes are picked out of txbuf by index, so a single ACK/NAK sits in byte 0.
  assign tx_byte = txbuf_q[{txidx_q, 3'b000} +: 8];

  always_comb begin
    case (mem_sel_q)
      2'd0:    rdata_sel = mem_rdata_a;
      2'd1:    rdata_sel = mem_rdata_b;
      default: rdata_sel = {24'd0, mem_rdata_c};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    sel_d      = sel_q;
    addr_h_d   = addr_h_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    txbuf_d    = txbuf_q;
    txidx_d    = txidx_q;
    txhold_d   = txhold_q;
    mem_sel_d  = mem_sel_q;
    mem_addr_d = mem_addr_q;
    nak        = 1'b0;
    tx_start   = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    cmd_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            is_wr_d = (rx_data == CMD_W);
            state_d = S_GET_SEL;
          end else begin
            nak = 1'b1;
          end
        end
      end
      S_GET_SEL: begin
        if (rx_ready) begin
          if (rx_data > 8'd2) begin
            nak = 1'b1;
          end else begin
            sel_d   = rx_data[1:0];
            state_d = S_GET_AH;
          end
        end
      end
      S_GET_AH: begin
        if (rx_ready) begin
          addr_h_d = rx_data;
          state_d  = S_GET_AL;
        end
      end
      S_GET_AL: begin
        if (rx_ready) begin
          addr_d = ADDR_W'({addr_h_q, rx_data});
          if (is_wr_q) begin
            cnt_d   = 2'd0;
            state_d = S_GET_DATA;
          end else begin
            mem_sel_d  = sel_q;
            mem_addr_d = ADDR_W'({addr_h_q, rx_data});
            state_d    = S_MEM_RD;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_ready) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            mem_sel_d  = sel_q;
            mem_addr_d = addr_q;
            state_d    = S_MEM_WR;
          end
        end
      end
      S_MEM_WR: begin
        mem_we  = 1'b1;
        txbuf_d = {24'd0, ACK_BYTE};
        txidx_d = 2'd0;
        state_d = S_TX_LOAD;
      end
      S_MEM_RD: begin
        mem_re  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        txbuf_d = rdata_sel;
        txidx_d = 2'd3;
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          txhold_d = 1'b1;
          state_d  = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // The UART raises tx_busy one clock late, so skip the first cycle before trusting it.
        if (txhold_q) begin
          txhold_d = 1'b0;
        end else if (!tx_busy) begin
          if (txidx_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            txidx_d = txidx_q - 2'd1;
            state_d = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (nak) begin
      txbuf_d = {24'd0, NAK_BYTE};
      txidx_d = 2'd0;
      cmd_err = 1'b1;
      state_d = S_TX_LOAD;
    end

    if (state_q inside {S_GET_SEL, S_GET_AH, S_GET_AL, S_GET_DATA}) begin
      if (rx_ready) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        cmd_err = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign tx_data   = tx_start ? tx_byte : 8'd0;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
